// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants and types for the SPI slave receiver.
//   DATA_W_DEF : default frame length in bits
//   CNT_W      : width of the bit_count output
//   state_t    : receiver FSM states (IDLE, SHIFT, HOLD)
// -----------------------------------------------------------------------------
package spi_pkg;
   localparam int DATA_W_DEF = 64;
   localparam int CNT_W      = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchronizer for one asynchronous input plus rise/fall detection
// on the synchronized level.
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_async  : asynchronous input
//   o_sync   : synchronized level
//   o_rise   : one-cycle pulse on a synchronized 0->1 transition
//   o_fall   : one-cycle pulse on a synchronized 1->0 transition
// Parameters: SYNC_STAGES (flop depth, >= 1), RST_VAL (idle level of the line;
// reset loads it everywhere so no false edge appears after reset).
// -----------------------------------------------------------------------------
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync[0] <= i_async;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_sync = r_sync[SYNC_STAGES-1];
   assign o_rise = o_sync & ~r_prev;
   assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
// SPI slave (mode 0, MSB first) receiver running entirely in the sclk_s domain.
// spi_sclk / spi_cs / spi_mosi are oversampled through spi_sync_edge, so sclk_s
// must be at least 4x spi_sclk.
//   sclk_s    : system clock          reset_n  : async active-low reset
//   spi_sclk  : SPI clock (async)     spi_cs   : chip select, active low
//   spi_mosi  : serial data in        spi_miso : serial data out
//   tx_data   : response word         tx_load  : load tx_data (IDLE only)
//   rx_data   : last complete word    rx_valid : unacknowledged word present
//   rx_ack    : consumer acknowledge  overrun  : sticky, word lost
//   frame_err : 1-cycle pulse, cs released mid-frame
//   bit_count : bits received in the current frame (saturates at DATA_W)
// Optional feature: define SPI_SLAVE_MISO_EN to build the transmit shifter;
// otherwise spi_miso is tied to 0 and tx_data/tx_load are ignored.
// -----------------------------------------------------------------------------
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              sclk_s,
   input  logic              reset_n,
   input  logic              spi_sclk,
   input  logic              spi_cs,
   input  logic              spi_mosi,
   output logic              spi_miso,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ack,
   output logic              overrun,
   output logic              frame_err,
   output logic [CNT_W-1:0]  bit_count
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

   // synchronized inputs
   logic w_sclk_rise, w_sclk_fall, w_sclk_lvl_unused;
   logic w_cs_rise, w_cs_fall, w_cs_lvl_unused;
   logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .i_clk(sclk_s), .i_rst_n(reset_n), .i_async(spi_sclk),
      .o_sync(w_sclk_lvl_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .i_clk(sclk_s), .i_rst_n(reset_n), .i_async(spi_cs),
      .o_sync(w_cs_lvl_unused), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .i_clk(sclk_s), .i_rst_n(reset_n), .i_async(spi_mosi),
      .o_sync(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
   );

   // FSM
   state_t            r_state, w_next;
   logic              w_done;    // last bit of the frame sampled this cycle
   logic              w_abort;   // cs released before the frame completed
   logic [DATA_W-1:0] r_shift;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [DATA_W-1:0] r_rx_data;
   logic              r_rx_valid, r_overrun, r_frame_err;
   logic [DATA_W-1:0] w_word;

   assign w_word = {r_shift[DATA_W-2:0], w_mosi};

   always_ff @(posedge sclk_s or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_done  = 1'b0;
      w_abort = 1'b0;
      case (r_state)
         IDLE:  if (w_cs_fall) w_next = SHIFT;
         SHIFT: begin
            // cs release wins over a coincident clock edge
            if (w_cs_rise) begin
               w_next  = IDLE;
               w_abort = 1'b1;
            end else if (w_sclk_rise && r_bit_cnt == LAST_BIT) begin
               w_next = HOLD;
               w_done = 1'b1;
            end
         end
         HOLD:  if (w_cs_rise) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // receive shifter and bit counter
   always_ff @(posedge sclk_s or negedge reset_n) begin
      if (!reset_n) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else if (r_state == IDLE && w_cs_fall) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else if (r_state == SHIFT && !w_cs_rise && w_sclk_rise) begin
         r_shift <= w_word;
         if (r_bit_cnt != FULL_CNT) r_bit_cnt <= r_bit_cnt + 1'b1;
      end else if (w_abort) begin
         r_shift <= '0;
      end
   end

   // output word, valid/ack handshake, overrun and frame error
   always_ff @(posedge sclk_s or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_abort;
         if (w_done) begin
            r_rx_data  <= w_word;
            r_rx_valid <= 1'b1;
            // an ack in the completion cycle consumes the old word, no loss
            if (rx_ack)          r_overrun <= 1'b0;
            else if (r_rx_valid) r_overrun <= 1'b1;
         end else if (rx_ack) begin
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
         end
      end
   end

   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign overrun   = r_overrun;
   assign frame_err = r_frame_err;
   assign bit_count = r_bit_cnt;

`ifdef SPI_SLAVE_MISO_EN
   // transmit shifter: MSB drives miso, shifted on each sclk falling edge
   logic [DATA_W-1:0] r_tx_shift;

   always_ff @(posedge sclk_s or negedge reset_n) begin
      if (!reset_n)                          r_tx_shift <= '0;
      else if (r_state == IDLE && tx_load)   r_tx_shift <= tx_data;
      else if (r_state == SHIFT && w_sclk_fall)
         r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
   end

   assign spi_miso = r_tx_shift[DATA_W-1];
`else
   logic w_unused_tx;
   assign w_unused_tx = ^{tx_data, tx_load, w_sclk_fall};
   assign spi_miso    = 1'b0;
`endif

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter DATA_W, default 64, frame length in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on spi_sclk, spi_cs and spi_mosi.
REQ-003 sclk_s  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 spi_sclk  input  1  serial clock from the SPI master, asynchronous to sclk_s.
REQ-006 spi_cs  input  1  chip select, active-low.
REQ-007 spi_mosi  input  1  serial data, MSB first.
REQ-008 spi_miso  output  1  serial response data, MSB first.
REQ-009 tx_data  input  DATA_W  response word.
REQ-010 tx_load  input  1  loads tx_data into the transmit shifter.
REQ-011 rx_data  output  DATA_W  last complete received word.
REQ-012 rx_valid  output  1  rx_data holds an unacknowledged word.
REQ-013 rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-014 overrun  output  1  sticky flag: a word completed while rx_valid was high.
REQ-015 frame_err  output  1  one-cycle pulse: cs deasserted mid-frame.
REQ-016 bit_count  output  7  bits received in the current frame.

Function
REQ-017 spi_sclk, spi_cs and spi_mosi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized signals; sclk_s SHALL be >= 4x spi_sclk.
REQ-018 FSM states: IDLE, SHIFT, HOLD.
REQ-019 IDLE -> SHIFT on a synchronized cs falling edge; bit_count SHALL clear to 0.
REQ-020 In SHIFT, each synchronized spi_sclk rising edge SHALL shift the synchronized mosi into the LSB of the receive shifter and increment bit_count.
REQ-021 When bit_count reaches DATA_W: rx_data SHALL load the shifter; rx_valid SHALL go high on the next sclk_s edge; the FSM SHALL enter HOLD.
REQ-022 In HOLD, further sclk edges SHALL be ignored; cs rising SHALL return the FSM to IDLE without flagging an error.
REQ-023 In SHIFT, cs rising with bit_count < DATA_W SHALL:
  - discard the partial word;
  - pulse frame_err for one cycle;
  - return the FSM to IDLE;
  - leave rx_data and rx_valid unchanged.
REQ-024 rx_ack with rx_valid high SHALL clear rx_valid on the next edge; rx_ack with rx_valid low SHALL have no effect.
REQ-025 A word completing while rx_valid is high and rx_ack is low SHALL:
  - overwrite rx_data;
  - keep rx_valid high;
  - set overrun.
REQ-026 A word completing in the same cycle as rx_ack SHALL:
  - load rx_data;
  - keep rx_valid high;
  - not set overrun.
REQ-027 overrun SHALL clear only on rx_ack or reset.
REQ-028 tx_load SHALL be accepted only in IDLE and ignored otherwise.
REQ-029 spi_miso SHALL present the MSB of the transmit shifter; each synchronized sclk falling edge in SHIFT SHALL shift it left, filling with 0.
REQ-030 bit_count SHALL saturate at DATA_W and never wrap.

Reset
REQ-031 reset_n low SHALL force:
  - FSM to IDLE;
  - all shifters, rx_data and bit_count to 0;
  - rx_valid, overrun, frame_err and spi_miso to 0;
  - synchronizers to their idle values: cs = 1, sclk = 0, mosi = 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no frame_err pulse.

Configuration
REQ-033 With macro SPI_SLAVE_MISO_EN defined, the transmit shifter, tx_load and spi_miso behaviour of REQ-028 and REQ-029 SHALL be present.
REQ-034 Without SPI_SLAVE_MISO_EN, spi_miso SHALL be constant 0, tx_data and tx_load SHALL be ignored, and no transmit shifter SHALL exist.

Structure
REQ-035 A shared package spi_pkg SHALL hold:
  - the DATA_W default (64);
  - the FSM state typedef (IDLE, SHIFT, HOLD);
  - the bit_count width constant (7).
REQ-036 One sub-module, spi_sync_edge, SHALL implement the synchronizer plus rise/fall detection and be instantiated per input.

Verification
REQ-037 Frame 64'hA5A5_0000_FFFF_1234 MSB-first at sclk_s/8 -> rx_data = 64'hA5A5_0000_FFFF_1234, one rx_valid rise, overrun = 0.
REQ-038 cs rises after 20 bits -> frame_err pulses for exactly 1 cycle, rx_valid stays 0, next full frame 64'h1 is received correctly.
REQ-039 Two frames 64'h11 then 64'h22 with no rx_ack -> rx_data = 64'h22, overrun = 1; rx_ack then clears both rx_valid and overrun.
REQ-040 rx_ack asserted in the completion cycle of a frame -> rx_valid stays 1, overrun = 0.
REQ-041 With SPI_SLAVE_MISO_EN: tx_load of 64'hDEAD_BEEF_0000_0001 in IDLE, then a full frame -> miso bitstream equals that word MSB-first.
REQ-042 reset_n low at bit 30 -> all outputs 0; a following full frame 64'hC3 is received correctly.
